// File: rtl/regfile_seq_ctrl.sv
// Command sequencer for the 4-entry register file (A, B, C, IX): single-cycle
// register ops plus multi-cycle SAVE/RESTORE block transfers to a byte-wide scratch memory.
module regfile_seq_ctrl #(
  parameter int SAVE_LEN = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [1:0] CMD_DST,
  input  logic [1:0] CMD_SRC,
  input  logic [7:0] CMD_DATA,
  output logic       DONE,
  output logic       ERR,
  output logic       MRWE,
  output logic [1:0] WA,
  output logic [4:0] RA,
  output logic       SWAPR,
  output logic [7:0] RF_IN,
  input  logic [7:0] RF_OUTA,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_WE,
  output logic       MEM_RE,
  output logic [7:0] MEM_WDATA,
  input  logic [7:0] MEM_RDATA
);

  generate
    if (SAVE_LEN != 4) begin : g_bad_cfg
      $error("regfile_seq_ctrl: SAVE_LEN must be 4");
    end
  endgenerate

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOADI   = 3'd1;
  localparam logic [2:0] OP_MOVE    = 3'd2;
  localparam logic [2:0] OP_SWAP    = 3'd3;
  localparam logic [2:0] OP_SAVE    = 3'd4;
  localparam logic [2:0] OP_RESTORE = 3'd5;

  localparam logic [2:0] IDX_LAST = 3'(SAVE_LEN - 1);
  localparam logic [2:0] IDX_FULL = 3'(SAVE_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC1  = 3'd1,
    S_SAVE   = 3'd2,
    S_RST_RD = 3'd3,
    S_RST_WR = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [2:0] op;
  logic [1:0] dst, src;
  logic [7:0] data;
  logic [7:0] addr;
  logic [2:0] idx;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Command fields are latched on accept; the block pointers walk during transfers.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && CMD_VALID) begin
      op   <= CMD_OP;
      dst  <= CMD_DST;
      src  <= CMD_SRC;
      data <= CMD_DATA;
      addr <= CMD_DATA;
      idx  <= 3'd0;
    end else if (state == S_SAVE || state == S_RST_RD || state == S_RST_WR) begin
      addr <= addr + 8'd1;
      idx  <= idx + 3'd1;
    end
  end

  always_comb begin
    state_nx  = state;
    CMD_READY = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;
    MRWE      = 1'b0;
    WA        = 2'd0;
    RA        = 5'd0;
    SWAPR     = 1'b0;
    RF_IN     = 8'd0;
    MEM_ADDR  = 8'd0;
    MEM_WE    = 1'b0;
    MEM_RE    = 1'b0;
    MEM_WDATA = 8'd0;
    case (state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          if (CMD_OP == OP_SAVE)         state_nx = S_SAVE;
          else if (CMD_OP == OP_RESTORE) state_nx = S_RST_RD;
          else                           state_nx = S_EXEC1;
        end
      end
      S_EXEC1: begin
        DONE     = 1'b1;
        state_nx = S_IDLE;
        case (op)
          OP_NOP: ;
          OP_LOADI: begin
            MRWE  = 1'b1;
            WA    = dst;
            RF_IN = data;
          end
          OP_MOVE: begin
            RA[1:0] = src;
            RF_IN   = RF_OUTA;
            MRWE    = 1'b1;
            WA      = dst;
          end
          OP_SWAP: begin
            // A self-swap degenerates to a NOP rather than strobing the file.
            if (dst != src) begin
              SWAPR   = 1'b1;
              RA[1:0] = dst;
              RA[3:2] = src;
            end
          end
          default: ERR = 1'b1;
        endcase
      end
      S_SAVE: begin
        RA[1:0]   = idx[1:0];
        MEM_WE    = 1'b1;
        MEM_ADDR  = addr;
        MEM_WDATA = RF_OUTA;
        if (idx == IDX_LAST) begin
          DONE     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_RST_RD: begin
        MEM_RE   = 1'b1;
        MEM_ADDR = addr;
        state_nx = S_RST_WR;
      end
      S_RST_WR: begin
        // Memory read data lags the read strobe by one cycle, so the write index trails by one.
        MRWE  = 1'b1;
        WA    = idx[1:0] - 2'd1;
        RF_IN = MEM_RDATA;
        if (idx == IDX_FULL) begin
          DONE     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          MEM_RE   = 1'b1;
          MEM_ADDR = addr;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl with behavioural register-file and scratch-memory models.
module tb_regfile_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_src;
  logic [7:0] cmd_data;
  logic       done, err, mrwe, swapr, mem_we, mem_re;
  logic [1:0] wa;
  logic [4:0] ra;
  logic [7:0] rf_in, rf_outa, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] rf [4];
  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_seq_ctrl #(.SAVE_LEN(4)) dut (
    .CLK(clk), .RESET(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_OP(cmd_op), .CMD_DST(cmd_dst), .CMD_SRC(cmd_src), .CMD_DATA(cmd_data),
    .DONE(done), .ERR(err), .MRWE(mrwe), .WA(wa), .RA(ra), .SWAPR(swapr),
    .RF_IN(rf_in), .RF_OUTA(rf_outa), .MEM_ADDR(mem_addr), .MEM_WE(mem_we),
    .MEM_RE(mem_re), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
  );

  // Register file: combinational port A, write or swap on the clock edge.
  assign rf_outa = rf[ra[1:0]];
  always @(posedge clk) begin
    if (mrwe) rf[wa] <= rf_in;
    if (swapr) begin
      rf[ra[1:0]] <= rf[ra[3:2]];
      rf[ra[3:2]] <= rf[ra[1:0]];
    end
  end

  // Scratch memory: one-cycle read latency; pre_* lets the bench preload contents.
  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                       input logic [7:0] dat);
    cmd_op = op; cmd_dst = d; cmd_src = s; cmd_data = dat; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic loadi(input logic [1:0] d, input logic [7:0] dat);
    issue(3'd1, d, 2'd0, dat);
    cyc();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mrwe"}, 32'(mrwe), 32'd0);
    chk({tag, "_swapr"}, 32'(swapr), 32'd0);
    chk({tag, "_memwe"}, 32'(mem_we), 32'd0);
    chk({tag, "_memre"}, 32'(mem_re), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_addr = 8'd0; pre_data = 8'd0;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 2'd0; cmd_src = 2'd0; cmd_data = 8'h77;

    // Reset held with a command pending.
    cyc();
    cyc();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk_quiet("rst");
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_ra", 32'(ra), 32'd0);
    chk("rst_rfin", 32'(rf_in), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    chk("rst_mwdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    cyc();
    cmd_valid = 1'b0;
    chk("post_rst_mrwe", 32'(mrwe), 32'd1);
    chk("post_rst_wa", 32'(wa), 32'd0);
    chk("post_rst_rfin", 32'(rf_in), 32'h77);
    chk("post_rst_done", 32'(done), 32'd1);
    cyc();

    // LOADI then MOVE.
    issue(3'd1, 2'd2, 2'd0, 8'h5A);
    chk("loadi_mrwe", 32'(mrwe), 32'd1);
    chk("loadi_wa", 32'(wa), 32'd2);
    chk("loadi_rfin", 32'(rf_in), 32'h5A);
    chk("loadi_done", 32'(done), 32'd1);
    chk("loadi_ready_busy", 32'(cmd_ready), 32'd0);
    chk("loadi_swapr", 32'(swapr), 32'd0);
    cyc();
    chk("loadi_ready_after", 32'(cmd_ready), 32'd1);
    chk("loadi_done_after", 32'(done), 32'd0);
    chk("loadi_rf2", 32'(rf[2]), 32'h5A);
    issue(3'd2, 2'd0, 2'd2, 8'h00);
    chk("move_ra", 32'(ra), 32'd2);
    chk("move_rfin", 32'(rf_in), 32'h5A);
    chk("move_wa", 32'(wa), 32'd0);
    chk("move_mrwe", 32'(mrwe), 32'd1);
    cyc();
    chk("move_rfA", 32'(rf[0]), 32'h5A);

    // SWAP B <-> IX, then self-swap.
    loadi(2'd1, 8'h11);
    loadi(2'd3, 8'h22);
    issue(3'd3, 2'd1, 2'd3, 8'h00);
    chk("swap_swapr", 32'(swapr), 32'd1);
    chk("swap_ra", 32'(ra), 32'h0D);
    chk("swap_mrwe", 32'(mrwe), 32'd0);
    chk("swap_done", 32'(done), 32'd1);
    cyc();
    chk("swap_rfB", 32'(rf[1]), 32'h22);
    chk("swap_rfIX", 32'(rf[3]), 32'h11);
    issue(3'd3, 2'd2, 2'd2, 8'h00);
    chk("selfswap_swapr", 32'(swapr), 32'd0);
    chk("selfswap_mrwe", 32'(mrwe), 32'd0);
    chk("selfswap_done", 32'(done), 32'd1);
    cyc();

    // SAVE with address wrap.
    loadi(2'd0, 8'h01);
    loadi(2'd1, 8'h02);
    loadi(2'd2, 8'h03);
    loadi(2'd3, 8'h04);
    issue(3'd4, 2'd0, 2'd0, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("save%0d_we", i), 32'(mem_we), 32'd1);
      chk($sformatf("save%0d_re", i), 32'(mem_re), 32'd0);
      chk($sformatf("save%0d_addr", i), 32'(mem_addr), 32'(8'(8'hFE + i)));
      chk($sformatf("save%0d_wdata", i), 32'(mem_wdata), 32'(i + 1));
      chk($sformatf("save%0d_done", i), 32'(done), 32'(i == 3));
      cyc();
    end
    chk("save_ready_after", 32'(cmd_ready), 32'd1);
    chk("save_memFE", 32'(mem[8'hFE]), 32'h01);
    chk("save_mem01", 32'(mem[8'h01]), 32'h04);

    // RESTORE from 0x10.
    for (int i = 0; i < 4; i++) begin
      pre_we = 1'b1; pre_addr = 8'(8'h10 + i); pre_data = 8'(8'hA0 + i);
      cyc();
    end
    pre_we = 1'b0;
    issue(3'd5, 2'd0, 2'd0, 8'h10);
    chk("rst0_re", 32'(mem_re), 32'd1);
    chk("rst0_addr", 32'(mem_addr), 32'h10);
    chk("rst0_mrwe", 32'(mrwe), 32'd0);
    chk("rst0_done", 32'(done), 32'd0);
    cyc();
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("rst%0d_re", k), 32'(mem_re), 32'd1);
      chk($sformatf("rst%0d_addr", k), 32'(mem_addr), 32'(8'h10 + k));
      chk($sformatf("rst%0d_mrwe", k), 32'(mrwe), 32'd1);
      chk($sformatf("rst%0d_wa", k), 32'(wa), 32'(k - 1));
      chk($sformatf("rst%0d_rfin", k), 32'(rf_in), 32'(8'hA0 + k - 1));
      chk($sformatf("rst%0d_done", k), 32'(done), 32'd0);
      cyc();
    end
    chk("rst4_re", 32'(mem_re), 32'd0);
    chk("rst4_mrwe", 32'(mrwe), 32'd1);
    chk("rst4_wa", 32'(wa), 32'd3);
    chk("rst4_rfin", 32'(rf_in), 32'hA3);
    chk("rst4_done", 32'(done), 32'd1);
    cyc();
    chk("restore_A", 32'(rf[0]), 32'hA0);
    chk("restore_B", 32'(rf[1]), 32'hA1);
    chk("restore_C", 32'(rf[2]), 32'hA2);
    chk("restore_IX", 32'(rf[3]), 32'hA3);

    // Reset in the middle of a SAVE, then an illegal opcode.
    issue(3'd4, 2'd0, 2'd0, 8'h40);
    chk("abort_c0_we", 32'(mem_we), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk_quiet("abort");
    cyc();
    chk("abort_stays_idle", 32'(cmd_ready), 32'd1);
    chk("abort_no_we", 32'(mem_we), 32'd0);
    issue(3'd7, 2'd1, 2'd2, 8'h33);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_done", 32'(done), 32'd1);
    chk_quiet("illegal");
    cyc();
    chk("illegal_err_after", 32'(err), 32'd0);
    chk("illegal_ready_after", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Command-driven initiator for the 4-entry main register file (A, B, C, IX). It accepts register-level operations over a valid/ready handshake and drives the file's write-enable, write-address, read-address, swap and data-in controls.
- It samples the file's OUTA read port for moves and saves.
- It also runs multi-cycle SAVE/RESTORE block transfers between the register file and a byte-wide scratch memory (context save for interrupts/calls).
- It sits between the instruction decoder and the register file.

Parameters:
- SAVE_LEN, 4, number of registers transferred by SAVE/RESTORE. Order is A, B, C, IX. Fixed at 4; any other value is a configuration error.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  3  0 NOP, 1 LOADI, 2 MOVE, 3 SWAP, 4 SAVE, 5 RESTORE, 6-7 illegal.
- CMD_DST  in  2  destination register index (0 A, 1 B, 2 C, 3 IX).
- CMD_SRC  in  2  source register index.
- CMD_DATA  in  8  immediate for LOADI; base address for SAVE/RESTORE.
- DONE  out  1  one-cycle pulse in the last execution cycle of a command.
- ERR  out  1  one-cycle pulse when an illegal opcode is accepted.
- MRWE  out  1  register-file write enable.
- WA  out  2  register-file write address.
- RA  out  5  register-file read controls. RA[1:0] selects port A; RA[3:2] selects port B; RA[4] is held 0.
- SWAPR  out  1  register-file swap strobe.
- RF_IN  out  8  register-file write data.
- RF_OUTA  in  8  register-file port-A read data, combinational from RA[1:0].
- MEM_ADDR  out  8  scratch memory address.
- MEM_WE  out  1  scratch memory write strobe.
- MEM_RE  out  1  scratch memory read strobe.
- MEM_WDATA  out  8  scratch memory write data.
- MEM_RDATA  in  8  scratch memory read data. Valid exactly one cycle after MEM_RE.

Behaviour:
- States: IDLE, EXEC1, SAVE, RST_RD, RST_WR. Registered: state, op, dst, src, data, addr pointer, 3-bit index.
- Reset: state IDLE. CMD_READY=1. DONE, ERR, MRWE, SWAPR, MEM_WE, MEM_RE=0. WA, RA, RF_IN, MEM_ADDR, MEM_WDATA=0.
- Reset mid-command abandons it at once. No further strobes and no DONE are issued.
- Handshake:
  - CMD_READY=1 only in IDLE.
  - A command is accepted on a cycle with CMD_VALID & CMD_READY; its fields are latched.
  - Execution starts the next cycle. Inputs are ignored while busy.
- All strobes are combinational from registered state. They are 0 in IDLE.
- NOP: EXEC1 for 1 cycle, no strobes, DONE=1.
- Illegal op: as NOP, with ERR=1 together with DONE.
- LOADI: EXEC1 for 1 cycle. MRWE=1, WA=dst, RF_IN=data, DONE=1.
- MOVE: EXEC1 for 1 cycle. RA[1:0]=src, RF_IN=RF_OUTA, MRWE=1, WA=dst, DONE=1. If dst==src, the write is still issued; it is harmless.
- SWAP: EXEC1 for 1 cycle. SWAPR=1, RA[1:0]=dst, RA[3:2]=src, MRWE=0, DONE=1.
  - If dst==src, SWAPR stays 0 and the command completes as a NOP.
- SAVE: 4 cycles, index i=0..3.
  - Each cycle: RA[1:0]=i, MEM_WE=1, MEM_ADDR=base+i, MEM_WDATA=RF_OUTA.
  - DONE=1 on i=3.
- RESTORE: 5 cycles.
  - Cycle 0 (RST_RD): MEM_RE=1, MEM_ADDR=base.
  - Cycles k=1..3: MEM_RE=1, MEM_ADDR=base+k. Also MRWE=1, WA=k-1, RF_IN=MEM_RDATA.
  - Cycle 4: MEM_RE=0, MRWE=1, WA=3, RF_IN=MEM_RDATA, DONE=1.
- Address arithmetic is 8-bit modulo 256: 0xFE+3 = 0x01.
- Back-to-back: after DONE the state returns to IDLE. The minimum command spacing is therefore 2 cycles (accept, execute).
- Never assert MRWE and SWAPR in the same cycle. Never assert MEM_WE and MEM_RE in the same cycle.

Test Plan:
- Reset: RESET high for 2 cycles with CMD_VALID=1 -> CMD_READY=1 and all strobes 0. The command is not accepted until the first cycle with RESET low.
- LOADI dst=2, data=0x5A -> next cycle MRWE=1, WA=2, RF_IN=0x5A, DONE=1. The cycle after that CMD_READY=1. Follow with MOVE src=2 dst=0 against a register-file model -> A=0x5A.
- SWAP dst=1 src=3 with B=0x11, IX=0x22 -> one cycle with SWAPR=1, RA[1:0]=1, RA[3:2]=3, MRWE=0. Then B=0x22, IX=0x11. SWAP dst=src=2 -> SWAPR stays 0, DONE=1.
- SAVE base=0xFE with A..IX=0x01,0x02,0x03,0x04 -> MEM writes (0xFE,0x01), (0xFF,0x02), (0x00,0x03), (0x01,0x04) on consecutive cycles; DONE on the 4th.
- RESTORE base=0x10 with memory holding 0xA0..0xA3 -> MEM_RE on cycles 0-3. Register writes A=0xA0, B=0xA1, C=0xA2, IX=0xA3 on cycles 1-4; DONE on cycle 4.
- RESET asserted during cycle 2 of SAVE -> next cycle IDLE with no MEM_WE. Then CMD_OP=7 -> ERR=1 and DONE=1 in the same cycle, no strobes.
